ps2_keyboard: RTL
=================

// Module: ps2_keyboard
// PURPOSE
//  PS/2 keyboard front end. Receives device-to-host PS/2 frames, decodes set-2 scan codes
//  (make, F0 break, E0 extended) and drives the ascii/press pair consumed by the tank
//  direction logic. Sits between the board PS/2 pins and the direction/moving block.
// PARAMETERS
//  FILT_LEN     8      ps2_clk glitch-filter depth in clk samples (>=2)
//  TIMEOUT_CYC  50000  clk cycles without a ps2_clk falling edge before a partial frame aborts
// PORTS
//  clk        in   1  system clock, the only clock
//  rst_n      in   1  asynchronous, active-low reset
//  ps2_clk    in   1  raw PS/2 clock pin (asynchronous to clk)
//  ps2_data   in   1  raw PS/2 data pin (asynchronous to clk)
//  ascii      out  8  last mapped key: 8'h61 'a', 8'h64 'd', 8'h77 'w', 8'h73 's', 8'h20 space, 8'h0D enter
//  press      out  1  1 while the key in ascii is held; 0 after its break code
//  valid      out  1  one-cycle strobe on every ascii/press update, including typematic repeats
//  frame_err  out  1  one-cycle strobe: parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset: ascii=8'h00, press=0, valid=0, frame_err=0, both FSMs IDLE, ext/brk flags clear,
//   filter shift register all ones, timeout counter 0. Reset mid-frame discards the partial byte.
//  Input conditioning: 2-FF synchronisers on both pins. Filtered clock goes 0 only when all
//   FILT_LEN samples are 0, goes 1 only when all are 1, and otherwise holds. Falling edge = 1->0.
//  Frame FSM (states IDLE, DATA, PARITY, STOP), advances only on filtered falling edges:
//   IDLE: edge with data=0 -> DATA, bit count=0; edge with data=1 -> stay IDLE, no error.
//   DATA: shift data into byte LSB first; after the 8th bit -> PARITY.
//   PARITY: sample parity bit -> STOP.
//   STOP: frame good iff stop=1 and (8 data bits + parity) has odd popcount. Good frame ->
//    byte strobe the next cycle. Bad frame -> frame_err pulse, byte discarded. Always -> IDLE.
//   Timeout: in DATA, PARITY or STOP, the counter increments every cycle and clears on each
//    edge. When it reaches TIMEOUT_CYC: frame_err pulse, back to IDLE. An edge arriving in the
//    same cycle as expiry takes priority; the counter clears and no error is raised.
//  Decoder, one step per byte strobe:
//   8'hE0 -> set ext. 8'hF0 -> set brk. No output change for either.
//   Any other byte: look up (ext, byte), then clear ext and brk.
//   Map, ext=0: 1C->61, 23->64, 1D->77, 1B->73, 29->20, 5A->0D.
//   Map, ext=1 (arrows): 6B->61, 74->64, 75->77, 72->73. Other codes are unmapped.
//   Mapped make: ascii<=code, press<=1, valid=1. A repeat of the same make also pulses valid.
//   Mapped break: if code==ascii then press<=0 and valid=1, ascii holds; otherwise ignored.
//   Unmapped make or break: no output change, no valid.
//  Latency: ascii/press/valid update exactly 2 clk cycles after the cycle in which the
//   stop-bit falling edge is detected (edge->byte strobe, strobe->output registers).
//  frame_err never coincides with valid for the same frame.
// STRUCTURE
//  Shared package tank_pkg: key ASCII constants (KEY_A, KEY_D, KEY_W, KEY_S, KEY_SPACE,
//   KEY_ENTER), scan-code constants (SC_E0, SC_F0, make codes), direction codes
//   LEFT/RIGHT/UP/DOWN = 3'b000/001/010/011.
//  Sub-module ps2_rx: synchronisers, filter, frame FSM and timeout; outputs rx_byte,
//   rx_strobe and frame_err. ps2_keyboard instantiates it and holds the decoder and
//   output registers.
// TESTING (PS/2 bit period 80 us, clk 25 MHz, FILT_LEN=8, TIMEOUT_CYC=50000)
//  1. Frame 1C, parity 0 -> ascii=8'h61, press=1, one valid pulse, 2 cycles after stop edge.
//  2. 1C then F0 1C -> press 0 with ascii=8'h61 and a second valid; 1C, 23, F0 1C ->
//     ascii=8'h64, press stays 1.
//  3. E0 75 then E0 F0 75 -> ascii=8'h77, press=1, then press=0; lone 75 (keypad 8) -> no change.
//  4. Frame 1C with bad parity (1), then frame 1C with stop bit 0 -> two frame_err pulses,
//     no valid, outputs unchanged.
//  5. Stop ps2_clk after 4 data bits -> frame_err at cycle 50000 after the last edge; the
//     next good frame 1D decodes to 8'h77.
//  6. 3-clk glitch pulses on ps2_clk, and rst_n asserted mid-frame -> no bit accepted;
//     after reset all outputs are 0 and the next frame decodes normally.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared tank constants: key ASCII codes, set-2 scan codes,
// direction codes, receiver states and the scan-code key map.
package tank_pkg;

  localparam logic [7:0] KEY_A     = 8'h61;
  localparam logic [7:0] KEY_D     = 8'h64;
  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_ENTER = 8'h0D;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [2:0] {
    LEFT  = 3'b000,
    RIGHT = 3'b001,
    UP    = 3'b010,
    DOWN  = 3'b011
  } dir_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [7:0] ascii;
  } key_map_t;

  function automatic key_map_t map_code(
    input logic       ext,
    input logic [7:0] code
  );
    key_map_t m;
    m.hit   = 1'b1;
    m.ascii = 8'h00;
    if (!ext) begin
      case (code)
        SC_A:     m.ascii = KEY_A;
        SC_D:     m.ascii = KEY_D;
        SC_W:     m.ascii = KEY_W;
        SC_S:     m.ascii = KEY_S;
        SC_SPACE: m.ascii = KEY_SPACE;
        SC_ENTER: m.ascii = KEY_ENTER;
        default:  m.hit   = 1'b0;
      endcase
    end else begin
      case (code)
        SC_LEFT:  m.ascii = KEY_A;
        SC_RIGHT: m.ascii = KEY_D;
        SC_UP:    m.ascii = KEY_W;
        SC_DOWN:  m.ascii = KEY_S;
        default:  m.hit   = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock
// glitch filter, frame FSM with parity/stop check and timeout.
module ps2_rx
  import tank_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [1:0]          ck_sync_q, ck_sync_d;
  logic [1:0]          dt_sync_q, dt_sync_d;
  logic [FILT_LEN-1:0] filt_q, filt_d;
  logic                fclk_q, fclk_d;
  rx_state_e           state_q, state_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                par_q, par_d;
  logic [CW-1:0]       tcnt_q, tcnt_d;
  logic                strobe_q, strobe_d;
  logic                err_q, err_d;
  logic                fall;
  logic                sdata;

  // Conditioning, frame sequencing and timeout supervision.
  always_comb begin
    ck_sync_d = {ck_sync_q[0], ps2_clk};
    dt_sync_d = {dt_sync_q[0], ps2_data};
    filt_d    = {filt_q[FILT_LEN-2:0], ck_sync_q[1]};
    fclk_d    = fclk_q;
    if (filt_q == '0) begin
      fclk_d = 1'b0;
    end else if (&filt_q) begin
      fclk_d = 1'b1;
    end
    fall     = fclk_q & ~fclk_d;
    sdata    = dt_sync_q[1];
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    tcnt_d   = '0;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    if (state_q != RX_IDLE) begin
      tcnt_d = fall ? '0 : tcnt_q + CW'(1);
    end
    unique case (state_q)
      RX_IDLE: begin
        if (fall && !sdata) begin
          state_d = RX_DATA;
          bcnt_d  = 3'd0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shreg_d = {sdata, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_d   = sdata;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d = RX_IDLE;
          if (sdata && (^{par_q, shreg_q})) begin
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (state_q != RX_IDLE && !fall && tcnt_q == TO_LAST) begin
      state_d = RX_IDLE;
      tcnt_d  = '0;
      err_d   = 1'b1;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
      filt_q    <= '1;
      fclk_q    <= 1'b1;
      state_q   <= RX_IDLE;
      bcnt_q    <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      tcnt_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ck_sync_q <= ck_sync_d;
      dt_sync_q <= dt_sync_d;
      filt_q    <= filt_d;
      fclk_q    <= fclk_d;
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tcnt_q    <= tcnt_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign rx_byte   = shreg_q;
  assign rx_strobe = strobe_q;
  assign frame_err = err_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: receiver plus set-2 make/break/
// extended decoder driving the tank ascii/press pair.
module ps2_keyboard
  import tank_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii,
  output logic       press,
  output logic       valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] ascii_q, ascii_d;
  logic       press_q, press_d;
  logic       valid_q, valid_d;
  key_map_t   m;

  ps2_rx #(
    .FILT_LEN   (FILT_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe),
    .frame_err(frame_err)
  );

  // Prefix tracking and key map lookup, one step per byte.
  always_comb begin
    m       = map_code(ext_q, rx_byte);
    ext_d   = ext_q;
    brk_d   = brk_q;
    ascii_d = ascii_q;
    press_d = press_q;
    valid_d = 1'b0;
    if (rx_strobe) begin
      unique case (1'b1)
        rx_byte == SC_E0: ext_d = 1'b1;
        rx_byte == SC_F0: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (m.hit && !brk_q) begin
            ascii_d = m.ascii;
            press_d = 1'b1;
            valid_d = 1'b1;
          end else if (m.hit && m.ascii == ascii_q) begin
            press_d = 1'b0;
            valid_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Decoder flags and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      ascii_q <= 8'h00;
      press_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      ascii_q <= ascii_d;
      press_q <= press_d;
      valid_q <= valid_d;
    end
  end

  assign ascii = ascii_q;
  assign press = press_q;
  assign valid = valid_q;

endmodule
